imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//   Program writer for the pipelined MIPS core's instruction memory.
//   Consumes a byte stream (valid/ready) carrying a 16-bit word count N and
//   4*N program bytes. Assembles the bytes into little-endian 32-bit words and
//   writes them to consecutive instruction-memory word addresses 0..N-1.
//   Holds the core in reset until the whole image is written, then releases it
//   so that fetch starts at PC=0.
// PARAMETERS
//   ADDR_W     8    instruction-memory word-address width
//   MAX_WORDS  256  largest accepted N; must be <= 2**ADDR_W
// PORTS
//   clk         in   1       system clock, rising edge
//   reset       in   1       asynchronous, active-high reset
//   byte_data   in   8       incoming stream byte
//   byte_valid  in   1       byte_data is valid
//   byte_ready  out  1       loader can accept a byte
//   start       in   1       one-cycle pulse: re-arm loader from DONE/ERR
//   imem_we     out  1       instruction-memory write strobe, one cycle per word
//   imem_addr   out  ADDR_W  word address for the write
//   imem_wdata  out  32      word to write
//   cpu_reset   out  1       reset to core, active-high
//   done        out  1       image loaded, core running
//   error       out  1       bad word count, core held in reset
// BEHAVIOUR
//   - Reset values: state=CNT_LO; byte_ready=0, imem_we=0, imem_addr=0,
//     imem_wdata=0, cpu_reset=1, done=0, error=0. All outputs are registered.
//   - Handshake: a byte is accepted on a rising edge where byte_valid && byte_ready.
//     byte_valid may toggle freely. The loader never drops an offered byte while
//     byte_ready=1.
//   - byte_ready=1 in CNT_LO, CNT_HI and DATA. It is 0 in DONE and ERR, and 0 in
//     the first cycle after reset release.
//   - FSM:
//     CNT_LO: accept -> N[7:0]=byte; go to CNT_HI.
//     CNT_HI: accept -> N[15:8]=byte.
//       If N==0 or N>MAX_WORDS: go to ERR.
//       Otherwise clear the byte index and word index, and go to DATA.
//     DATA: accept byte k (k=0..3) -> word[8k+7:8k].
//       On accepting k=3, at that same edge: imem_we<=1, imem_addr<=word index,
//       imem_wdata<=the assembled word (including the current byte). Then the
//       word index increments and k wraps to 0.
//       If the word index was N-1: go to DONE.
//     DONE: the edge after entry sets cpu_reset<=0 and done<=1. This gives the
//       last write one full cycle before the core leaves reset.
//       A start pulse re-arms the loader.
//     ERR: error<=1 on entry; cpu_reset stays 1; a start pulse re-arms the loader.
//   - Re-arm (start in DONE/ERR): next edge sets state=CNT_LO, cpu_reset=1,
//     done=0, error=0 and byte_ready=1. start is ignored in all other states.
//   - imem_we is high for exactly one cycle per word; otherwise 0.
//     imem_addr and imem_wdata hold their last values while imem_we=0.
//   - Latency: last byte of a word accepted -> imem_we high in the following cycle.
//   - An asynchronous reset mid-load aborts the load immediately and restores the
//     reset values. Partially written memory is not cleared.
// TESTING
//   1. N=2, bytes 02 00 | 78 56 34 12 | EF BE AD DE at one byte per cycle
//      -> writes addr0=0x12345678, addr1=0xDEADBEEF; cpu_reset falls one cycle
//      after the 2nd imem_we; done=1.
//   2. Same image with byte_valid toggled 1/0 every cycle -> identical writes.
//      Exactly 2 imem_we pulses.
//   3. N=0 (00 00) -> error=1, cpu_reset stays 1, no imem_we.
//      N=MAX_WORDS+1 -> same response.
//   4. N=MAX_WORDS full image -> last write at addr MAX_WORDS-1, done=1;
//      extra bytes offered afterwards are not accepted (byte_ready=0).
//   5. Assert reset after 5 DATA bytes, release, send N=1 with 0xCAFEF00D
//      -> single write addr0=0xCAFEF00D; no stale byte merged.
//   6. From DONE, pulse start and load N=1 with 0x00000001 -> cpu_reset goes back
//      to 1 and done to 0; after the load, addr0=0x00000001 and done=1.

Source files
------------

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a counted little-endian program image into instruction memory, then releases the core
module imem_boot_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              start,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
  localparam logic [2:0]  CNT_LO = 3'd0, CNT_HI = 3'd1, DATA = 3'd2, DONE = 3'd3, ERR = 3'd4;
  localparam logic [15:0] MAX_N  = 16'(MAX_WORDS);
  logic [2:0]  state;
  logic [15:0] n, widx, n_new;
  logic [1:0]  k;
  logic [23:0] wbuf;
  logic        acc;
  assign acc   = byte_valid && byte_ready;
  assign n_new = {byte_data, n[7:0]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CNT_LO;
      n          <= '0;
      widx       <= '0;
      k          <= '0;
      wbuf       <= '0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        CNT_LO: begin
          // ready rises here on the first cycle out of reset
          byte_ready <= 1'b1;
          if (acc) begin
            n[7:0] <= byte_data;
            state  <= CNT_HI;
          end
        end
        CNT_HI: if (acc) begin
          n[15:8] <= byte_data;
          if (n_new == 16'd0 || n_new > MAX_N) begin
            state      <= ERR;
            error      <= 1'b1;
            byte_ready <= 1'b0;
          end else begin
            k     <= '0;
            widx  <= '0;
            state <= DATA;
          end
        end
        DATA: if (acc) begin
          k <= k + 2'd1;
          if (k == 2'd3) begin
            imem_we    <= 1'b1;
            imem_addr  <= widx[ADDR_W-1:0];
            imem_wdata <= {byte_data, wbuf};
            widx       <= widx + 16'd1;
            if (widx == n - 16'd1) begin
              state      <= DONE;
              byte_ready <= 1'b0;
            end
          end else begin
            wbuf[8*k +: 8] <= byte_data;
          end
        end
        DONE: begin
          cpu_reset  <= start;
          done       <= !start;
          byte_ready <= start;
          if (start) state <= CNT_LO;
        end
        ERR: if (start) begin
          error      <= 1'b0;
          byte_ready <= 1'b1;
          state      <= CNT_LO;
        end
        default: state <= CNT_LO;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed scenarios for the instruction-memory boot loader
module tb_imem_boot_loader;
  logic        clk, reset, byte_valid, start;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_reset, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  int vec = 0, miss = 0;
  int wcnt = 0, mcyc = 0, last_we_cyc = 0, fall_cyc = -1;
  logic        prev_cr = 1'b1;
  logic [7:0]  wa [0:1023];
  logic [31:0] wd [0:1023];

  imem_boot_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
    .clk(clk), .reset(reset), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .start(start), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write/cpu_reset monitor sampling just after each rising edge
  always @(posedge clk) begin
    #1;
    mcyc++;
    if (imem_we) begin
      wa[wcnt] = imem_addr;
      wd[wcnt] = imem_wdata;
      wcnt++;
      last_we_cyc = mcyc;
    end
    if (prev_cr && !cpu_reset) fall_cyc = mcyc;
    prev_cr = cpu_reset;
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    byte_data = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 50) begin @(negedge clk); t++; end
    if (!byte_ready) begin
      vec++; miss++;
      $display("FAIL send_timeout: byte_ready=%b want 1 (byte %h)", byte_ready, b);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send(w[8*i +: 8]);
      if (gap) @(negedge clk);
    end
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) @(negedge clk);
  endtask

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle(2);
    vec++; if (byte_ready !== 1'b0) begin miss++; $display("FAIL rst_ready: got %b want 0", byte_ready); end
    vec++; if (imem_we !== 1'b0) begin miss++; $display("FAIL rst_we: got %b want 0", imem_we); end
    vec++; if (imem_addr !== 8'h00) begin miss++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
    vec++; if (imem_wdata !== 32'h0) begin miss++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
    vec++; if (cpu_reset !== 1'b1) begin miss++; $display("FAIL rst_cpu_reset: got %b want 1", cpu_reset); end
    vec++; if (done !== 1'b0) begin miss++; $display("FAIL rst_done: got %b want 0", done); end
    vec++; if (error !== 1'b0) begin miss++; $display("FAIL rst_error: got %b want 0", error); end
    reset = 1'b0;
    #1;
    vec++; if (byte_ready !== 1'b0) begin miss++; $display("FAIL rst_release_ready: got %b want 0", byte_ready); end
    @(negedge clk);
    vec++; if (byte_ready !== 1'b1) begin miss++; $display("FAIL rst_ready_rise: got %b want 1", byte_ready); end
  endtask

  task automatic test_basic;
    int base = wcnt;
    send(8'h02); send(8'h00);
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    idle(3);
    vec++; if (wcnt - base !== 2) begin miss++; $display("FAIL basic_count: got %0d want 2", wcnt - base); end
    vec++; if (wa[base] !== 8'h00 || wd[base] !== 32'h12345678) begin miss++; $display("FAIL basic_w0: got %h/%h want 00/12345678", wa[base], wd[base]); end
    vec++; if (wa[base+1] !== 8'h01 || wd[base+1] !== 32'hDEADBEEF) begin miss++; $display("FAIL basic_w1: got %h/%h want 01/deadbeef", wa[base+1], wd[base+1]); end
    vec++; if (fall_cyc !== last_we_cyc + 1) begin miss++; $display("FAIL basic_release_timing: got %0d want %0d", fall_cyc, last_we_cyc + 1); end
    vec++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin miss++; $display("FAIL basic_done: got done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
    vec++; if (imem_we !== 1'b0 || imem_addr !== 8'h01 || imem_wdata !== 32'hDEADBEEF) begin miss++; $display("FAIL basic_hold: got %b/%h/%h want 0/01/deadbeef", imem_we, imem_addr, imem_wdata); end
    vec++; if (byte_ready !== 1'b0) begin miss++; $display("FAIL basic_ready_done: got %b want 0", byte_ready); end
  endtask

  task automatic test_toggle;
    int base;
    pulse_start();
    vec++; if (done !== 1'b0 || cpu_reset !== 1'b1 || byte_ready !== 1'b1) begin miss++; $display("FAIL toggle_rearm: got done=%b cpu_reset=%b ready=%b want 0/1/1", done, cpu_reset, byte_ready); end
    base = wcnt;
    send(8'h02); @(negedge clk); send(8'h00); @(negedge clk);
    send_word(32'h12345678, 1'b1);
    send_word(32'hDEADBEEF, 1'b1);
    idle(3);
    vec++; if (wcnt - base !== 2) begin miss++; $display("FAIL toggle_count: got %0d want 2", wcnt - base); end
    vec++; if (wd[base] !== 32'h12345678 || wd[base+1] !== 32'hDEADBEEF || wa[base+1] !== 8'h01) begin miss++; $display("FAIL toggle_data: got %h %h @%h want 12345678 deadbeef @01", wd[base], wd[base+1], wa[base+1]); end
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL toggle_done: got %b want 1", done); end
  endtask

  task automatic test_bad_count;
    int base = wcnt;
    pulse_start();
    send(8'h00); send(8'h00);
    idle(3);
    vec++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin miss++; $display("FAIL zero_err: got err=%b cpu_reset=%b done=%b want 1/1/0", error, cpu_reset, done); end
    vec++; if (byte_ready !== 1'b0) begin miss++; $display("FAIL zero_ready: got %b want 0", byte_ready); end
    pulse_start();
    vec++; if (error !== 1'b0 || byte_ready !== 1'b1) begin miss++; $display("FAIL err_rearm: got err=%b ready=%b want 0/1", error, byte_ready); end
    send(8'h01); send(8'h01);
    idle(3);
    vec++; if (error !== 1'b1 || cpu_reset !== 1'b1) begin miss++; $display("FAIL over_err: got err=%b cpu_reset=%b want 1/1", error, cpu_reset); end
    vec++; if (wcnt - base !== 0) begin miss++; $display("FAIL bad_no_write: got %0d want 0", wcnt - base); end
    pulse_start();
  endtask

  task automatic test_max;
    int base = wcnt, bad = 0;
    send(8'h00); send(8'h01);
    for (int i = 0; i < 256; i++) send_word(32'hA5000000 | i, 1'b0);
    idle(3);
    vec++; if (wcnt - base !== 256) begin miss++; $display("FAIL max_count: got %0d want 256", wcnt - base); end
    for (int i = 0; i < 256; i++)
      if (wa[base+i] !== 8'(i) || wd[base+i] !== (32'hA5000000 | i)) bad++;
    vec++; if (bad !== 0) begin miss++; $display("FAIL max_words: got %0d bad words want 0", bad); end
    vec++; if (wa[base+255] !== 8'hFF) begin miss++; $display("FAIL max_last_addr: got %h want ff", wa[base+255]); end
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL max_done: got %b want 1", done); end
    base = wcnt;
    byte_data = 8'h55; byte_valid = 1'b1;
    idle(8);
    vec++; if (byte_ready !== 1'b0 || wcnt - base !== 0 || done !== 1'b1) begin miss++; $display("FAIL max_extra: got ready=%b writes=%0d done=%b want 0/0/1", byte_ready, wcnt - base, done); end
    byte_valid = 1'b0;
  endtask

  task automatic test_abort;
    int base;
    pulse_start();
    send(8'h02); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
    reset = 1'b1;
    #1;
    vec++; if (byte_ready !== 1'b0 || cpu_reset !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 32'h0) begin miss++; $display("FAIL abort_async: got ready=%b cpu_reset=%b addr=%h wdata=%h want 0/1/00/0", byte_ready, cpu_reset, imem_addr, imem_wdata); end
    @(negedge clk);
    reset = 1'b0;
    base = wcnt;
    send(8'h01); send(8'h00);
    send_word(32'hCAFEF00D, 1'b0);
    idle(3);
    vec++; if (wcnt - base !== 1) begin miss++; $display("FAIL abort_count: got %0d want 1", wcnt - base); end
    vec++; if (wa[base] !== 8'h00 || wd[base] !== 32'hCAFEF00D) begin miss++; $display("FAIL abort_word: got %h/%h want 00/cafef00d", wa[base], wd[base]); end
    vec++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin miss++; $display("FAIL abort_done: got done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
  endtask

  task automatic test_rearm;
    int base;
    pulse_start();
    vec++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin miss++; $display("FAIL rearm_state: got cpu_reset=%b done=%b want 1/0", cpu_reset, done); end
    base = wcnt;
    send(8'h01); send(8'h00);
    send_word(32'h00000001, 1'b0);
    idle(3);
    vec++; if (wcnt - base !== 1 || wa[base] !== 8'h00 || wd[base] !== 32'h00000001) begin miss++; $display("FAIL rearm_write: got n=%0d %h/%h want 1 00/00000001", wcnt - base, wa[base], wd[base]); end
    vec++; if (done !== 1'b1 || cpu_reset !== 1'b0) begin miss++; $display("FAIL rearm_done: got done=%b cpu_reset=%b want 1/0", done, cpu_reset); end
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; start = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_toggle();
    test_bad_count();
    test_max();
    test_abort();
    test_rearm();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
